// File: rtl/cam_wr_packer_pkg.sv
// rtl/cam_wr_packer_pkg.sv - shared types and constants for the camera write packer
package cam_pkg;

  localparam int PIX_PER_WORD = 8;
  localparam int PIX_W        = 16;
  localparam int WORD_W       = 128;
  localparam int ADDR_W       = 25;
  localparam int CNT_W        = $clog2(PIX_PER_WORD);

  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR_0     = 25'h0000000;
  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR_1     = 25'h0010000;
  localparam int                DEF_WORDS_PER_FRAME = 38400;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } cam_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } cam_entry_t;

endpackage

// File: rtl/cam_wr_packer_if.sv
// rtl/cam_wr_packer_if.sv - DDR write request bundle between packer and arbiter
interface cam_wr_if;
  import cam_pkg::*;

  logic              camera_wr_req;
  logic [ADDR_W-1:0] camera_wr_address;
  logic [WORD_W-1:0] camera_wr_data;
  logic              ram_busy;

  modport master (
    output camera_wr_req,
    output camera_wr_address,
    output camera_wr_data,
    input  ram_busy
  );

  modport slave (
    input  camera_wr_req,
    input  camera_wr_address,
    input  camera_wr_data,
    output ram_busy
  );

endinterface

// File: rtl/cam_wr_packer_fifo.sv
// rtl/cam_wr_packer_fifo.sv - first-word-fall-through FIFO of {address, word} entries
module cam_word_fifo
  import cam_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_133M,
  input  logic       rst_133M,
  input  logic       push_i,
  input  cam_entry_t entry_i,
  input  logic       pop_i,
  output cam_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  cam_entry_t    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_133M) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/cam_wr_packer.sv
// rtl/cam_wr_packer.sv - packs RGB565 pixels into 128-bit DDR write requests
// Define CAM_DOUBLE_BUFFER_EN to alternate frames between BASE_ADDR_0 and BASE_ADDR_1.
module cam_wr_packer
  import cam_pkg::*;
#(
  parameter int                DEPTH           = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR_0     = DEF_BASE_ADDR_0,
  parameter logic [ADDR_W-1:0] BASE_ADDR_1     = DEF_BASE_ADDR_1,
  parameter int                WORDS_PER_FRAME = DEF_WORDS_PER_FRAME
) (
  input  logic             clk_133M,
  input  logic             rst_133M,
  input  logic [PIX_W-1:0] pixel_data,
  input  logic             pixel_valid,
  input  logic             frame_start,
  input  logic             frame_end,
  cam_wr_if.master         wr,
  output logic             frame_done,
  output logic             done_buf,
  output logic             overflow
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WORDS_PER_FRAME < 1) begin : g_bad_cfg
    $error("cam_wr_packer: DEPTH must be a power of two >= 2, WORDS_PER_FRAME positive");
  end

  cam_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] word_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [WORD_W-1:0] req_data_q;
  logic              frame_done_q;
  logic              overflow_q;

  logic              buf_idx;
  logic [ADDR_W-1:0] cur_base;
  logic [WORD_W-1:0] lane_word;
  logic [WORD_W-1:0] packed_word;
  logic [CNT_W-1:0]  cnt_adv;
  logic              word_full;
  logic              push;
  logic              issue;
  logic              flush_done;
  cam_entry_t        push_entry;
  cam_entry_t        head;
  logic              fifo_full;
  logic              fifo_empty;

  always_comb begin
    lane_word = word_q;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (cnt_q == CNT_W'(i)) lane_word[i*PIX_W +: PIX_W] = pixel_data;
    end
  end

  // A pixel arriving with frame_end is packed first; a wrapped count means the word was full.
  assign packed_word = pixel_valid ? lane_word : word_q;
  assign cnt_adv     = cnt_q + CNT_W'(pixel_valid);
  assign word_full   = pixel_valid && (cnt_q == CNT_W'(PIX_PER_WORD - 1));
  assign push        = (state_q == ACTIVE) && !frame_start &&
                       (word_full || (frame_end && (cnt_adv != '0)));
  assign push_entry  = '{addr: addr_q, data: packed_word};
  assign issue       = !fifo_empty && !wr.ram_busy && !req_q;
  assign flush_done  = (state_q == FLUSH) && fifo_empty && !req_q;
  assign cur_base    = buf_idx ? BASE_ADDR_1 : BASE_ADDR_0;

  cam_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_133M (clk_133M),
    .rst_133M (rst_133M),
    .push_i   (push),
    .entry_i  (push_entry),
    .pop_i    (issue),
    .head_o   (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      req_q        <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      req_q        <= issue;
      req_addr_q   <= issue ? head.addr : '0;
      req_data_q   <= issue ? head.data : '0;
      frame_done_q <= 1'b0;
      if (push && fifo_full) overflow_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            word_q  <= '0;
            addr_q  <= cur_base;
          end
        end
        ACTIVE: begin
          if (frame_start) begin
            cnt_q  <= '0;
            word_q <= '0;
            addr_q <= cur_base;
          end else begin
            if (push) begin
              // Dropped words still consume their address.
              addr_q <= addr_q + ADDR_W'(1);
              word_q <= '0;
              cnt_q  <= '0;
            end else begin
              word_q <= packed_word;
              cnt_q  <= cnt_adv;
            end
            if (frame_end) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_done) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CAM_DOUBLE_BUFFER_EN
  logic buf_q;
  logic done_buf_q;

  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      buf_q      <= 1'b0;
      done_buf_q <= 1'b0;
    end else begin
      done_buf_q <= 1'b0;
      if (flush_done) begin
        done_buf_q <= buf_q;
        buf_q      <= ~buf_q;
      end
    end
  end

  assign buf_idx  = buf_q;
  assign done_buf = done_buf_q;
`else
  assign buf_idx  = 1'b0;
  assign done_buf = 1'b0;
`endif

  assign wr.camera_wr_req     = req_q;
  assign wr.camera_wr_address = req_addr_q;
  assign wr.camera_wr_data    = req_data_q;
  assign frame_done           = frame_done_q;
  assign overflow             = overflow_q;

endmodule

// File: tb/tb_cam_wr_packer.sv
// tb/tb_cam_wr_packer.sv - directed self-checking bench for cam_wr_packer
module tb_cam_wr_packer;
  import cam_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        frame_start;
  logic        frame_end;
  logic        frame_done;
  logic        done_buf;
  logic        overflow;

  cam_wr_if wr_if ();

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [24:0]  q_addr[$];
  logic [127:0] q_data[$];
  int           q_cyc[$];
  logic         q_buf[$];
  int           d_cyc[$];

`ifdef CAM_DOUBLE_BUFFER_EN
  localparam logic [24:0] BASE_B = 25'h0010000;
  localparam logic        BUF_B  = 1'b1;
`else
  localparam logic [24:0] BASE_B = 25'h0000000;
  localparam logic        BUF_B  = 1'b0;
`endif

  cam_wr_packer #(
    .DEPTH (4)
  ) dut (
    .clk_133M    (clk),
    .rst_133M    (rst),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .wr          (wr_if),
    .frame_done  (frame_done),
    .done_buf    (done_buf),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_if.camera_wr_req === 1'b1) begin
      q_addr.push_back(wr_if.camera_wr_address);
      q_data.push_back(wr_if.camera_wr_data);
      q_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      q_buf.push_back(done_buf);
      d_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic send_pixels(input logic [15:0] first, input int n, input logic end_on_last);
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b1;
      pixel_data  = first + 16'(i);
      frame_end   = end_on_last && (i == n - 1);
      step();
    end
    pixel_valid = 1'b0;
    frame_end   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int k = 0;
    while (d_cyc.size() < target && k < 300) begin
      step();
      k++;
    end
    chk(tag, 128'(d_cyc.size()), 128'(target));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"},  128'(wr_if.camera_wr_req), 128'(0));
    chk({tag, "_addr"}, 128'(wr_if.camera_wr_address), 128'(0));
    chk({tag, "_data"}, wr_if.camera_wr_data, 128'(0));
    chk({tag, "_done"}, 128'(frame_done), 128'(0));
    chk({tag, "_dbuf"}, 128'(done_buf), 128'(0));
    chk({tag, "_ovf"},  128'(overflow), 128'(0));
  endtask

  initial begin
    int rb;
    int db;
    int c8;
    int rel;

    rst              = 1'b1;
    pixel_data       = '0;
    pixel_valid      = 1'b0;
    frame_start      = 1'b0;
    frame_end        = 1'b0;
    wr_if.ram_busy   = 1'b0;

    // Reset state, then two full words of pixels 1..16.
    do_reset();
    chk_outputs_zero("reset");
    rb = q_addr.size();
    db = d_cyc.size();
    pulse_start();
    send_pixels(16'h0001, 8, 1'b0);
    c8 = cyc;
    send_pixels(16'h0009, 8, 1'b0);
    pulse_end();
    wait_done("t1_done", db + 1);
    step(3);
    chk("t1_nreq", 128'(q_addr.size() - rb), 128'(2));
    chk("t1_latency", 128'(q_cyc[rb]), 128'(c8 + 1));
    chk("t1_addr0", 128'(q_addr[rb]), 128'(0));
    chk("t1_data0", q_data[rb], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("t1_addr1", 128'(q_addr[rb+1]), 128'(1));
    chk("t1_data1", q_data[rb+1], 128'h0010_000F_000E_000D_000C_000B_000A_0009);
    chk("t1_done_after_last", 128'(d_cyc[db]), 128'(q_cyc[rb+1] + 2));

    // 11 pixels then frame_end: padded second word.
    do_reset();
    rb = q_addr.size();
    db = d_cyc.size();
    pulse_start();
    send_pixels(16'h0001, 11, 1'b0);
    pulse_end();
    wait_done("t2_done", db + 1);
    step(3);
    chk("t2_nreq", 128'(q_addr.size() - rb), 128'(2));
    chk("t2_addr1", 128'(q_addr[rb+1]), 128'(1));
    chk("t2_data1", q_data[rb+1], 128'h0000_0000_0000_0000_0000_000B_000A_0009);

    // frame_end together with the 10th pixel: pixel packed before padding.
    do_reset();
    rb = q_addr.size();
    db = d_cyc.size();
    pulse_start();
    send_pixels(16'h0021, 10, 1'b1);
    wait_done("t2b_done", db + 1);
    step(3);
    chk("t2b_nreq", 128'(q_addr.size() - rb), 128'(2));
    chk("t2b_data0", q_data[rb], 128'h0028_0027_0026_0025_0024_0023_0022_0021);
    chk("t2b_data1", q_data[rb+1], 128'h0000_0000_0000_0000_0000_0000_002A_0029);

    // frame_end with the 8th pixel: full word only, no padded extra.
    do_reset();
    rb = q_addr.size();
    db = d_cyc.size();
    pulse_start();
    send_pixels(16'h0031, 8, 1'b1);
    wait_done("t2c_done", db + 1);
    step(3);
    chk("t2c_nreq", 128'(q_addr.size() - rb), 128'(1));
    chk("t2c_data0", q_data[rb], 128'h0038_0037_0036_0035_0034_0033_0032_0031);

    // Back-pressure: 5 words into a 4-deep FIFO, one dropped.
    do_reset();
    rb = q_addr.size();
    db = d_cyc.size();
    wr_if.ram_busy = 1'b1;
    pulse_start();
    send_pixels(16'h0001, 40, 1'b0);
    pulse_end();
    step(4);
    chk("t3_ovf_set", 128'(overflow), 128'(1));
    chk("t3_no_req_busy", 128'(q_addr.size() - rb), 128'(0));
    chk("t3_no_done_busy", 128'(d_cyc.size() - db), 128'(0));
    wr_if.ram_busy = 1'b0;
    step();
    rel = cyc;
    wait_done("t3_done", db + 1);
    step(3);
    chk("t3_nreq", 128'(q_addr.size() - rb), 128'(4));
    chk("t3_resume", 128'(q_cyc[rb]), 128'(rel));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_addr%0d", i), 128'(q_addr[rb+i]), 128'(i));
    end
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t3_gap%0d", i), 128'(q_cyc[rb+i] - q_cyc[rb+i-1]), 128'(2));
    end
    chk("t3_data3", q_data[rb+3], 128'h0020_001F_001E_001D_001C_001B_001A_0019);
    chk("t3_ovf_sticky", 128'(overflow), 128'(1));

    // Restart mid-frame: partial word discarded, address back to base.
    do_reset();
    chk("t4_ovf_clear", 128'(overflow), 128'(0));
    rb = q_addr.size();
    db = d_cyc.size();
    pulse_start();
    send_pixels(16'h0051, 5, 1'b0);
    pulse_start();
    send_pixels(16'h0061, 8, 1'b0);
    pulse_end();
    wait_done("t4_done", db + 1);
    step(3);
    chk("t4_nreq", 128'(q_addr.size() - rb), 128'(1));
    chk("t4_addr0", 128'(q_addr[rb]), 128'(0));
    chk("t4_data0", q_data[rb], 128'h0068_0067_0066_0065_0064_0063_0062_0061);

    // Two back-to-back 8-pixel frames: buffer selection.
    do_reset();
    rb = q_addr.size();
    db = d_cyc.size();
    pulse_start();
    send_pixels(16'h0071, 8, 1'b0);
    pulse_end();
    wait_done("t5_done0", db + 1);
    pulse_start();
    send_pixels(16'h0081, 8, 1'b0);
    pulse_end();
    wait_done("t5_done1", db + 2);
    step(3);
    chk("t5_nreq", 128'(q_addr.size() - rb), 128'(2));
    chk("t5_addr0", 128'(q_addr[rb]), 128'(0));
    chk("t5_addr1", 128'(q_addr[rb+1]), 128'(BASE_B));
    chk("t5_data1", q_data[rb+1], 128'h0088_0087_0086_0085_0084_0083_0082_0081);
    chk("t5_buf0", 128'(q_buf[db]), 128'(0));
    chk("t5_buf1", 128'(q_buf[db+1]), 128'(BUF_B));

    // Reset mid-frame with two words queued.
    do_reset();
    rb = q_addr.size();
    db = d_cyc.size();
    wr_if.ram_busy = 1'b1;
    pulse_start();
    send_pixels(16'h0091, 21, 1'b0);
    rst = 1'b1;
    step();
    chk_outputs_zero("t6");
    rst = 1'b0;
    wr_if.ram_busy = 1'b0;
    step(20);
    chk("t6_nreq", 128'(q_addr.size() - rb), 128'(0));
    chk("t6_ndone", 128'(d_cyc.size() - db), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
